// File: rtl/watch_pkg.sv
// Shared types and helpers for the stopwatch/timer sequencer.
package watch_pkg;
   typedef enum logic {SW_STOP = 1'b0, SW_RUN = 1'b1} sw_state_t;
   typedef enum logic [1:0] {T_SET, T_RUN, T_PAUSE, T_ALARM} tmr_state_t;

   localparam logic MODE_SW  = 1'b0;
   localparam logic MODE_TMR = 1'b1;

   function automatic int cycles(input int hz, input int ms);
      return (hz / 1000) * ms;
   endfunction
endpackage

// File: rtl/watch_ctrl_debounce.sv
// Key debouncer: 2-FF synchronizer plus stability counter; one-cycle pulse on accepted press.
module key_debounce #(
   parameter int DB_CYC = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);
   localparam int CW = $clog2(DB_CYC + 1);

   logic          s1, s2, level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         s1    <= key_n;
         s2    <= s1;
         press <= 1'b0;
         // any return to the accepted level restarts the window
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYC - 1)) begin
            cnt   <= '0;
            level <= s2;
            press <= level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/watch_ctrl.sv
// Stopwatch/timer sequencer: key debounce, 100 Hz tick, both FSMs, display/buzzer control.
// Optional lap hold of the stopwatch display is compiled in with WATCH_CTRL_LAP_EN.
module watch_ctrl
   import watch_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TICK_HZ     = 100,
   parameter int DEBOUNCE_MS = 20,
   parameter int BEEP_SEC    = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic key_start,
   input  logic key_mode,
   input  logic key_clear,
   input  logic tmr_zero,
   output logic tick,
   output logic sw_run,
   output logic sw_clear,
   output logic tmr_load,
   output logic tmr_run,
   output logic disp_sel,
   output logic buzzer_en,
   output logic disp_freeze
);
   localparam int TICK_DIV   = CLK_HZ / TICK_HZ;
   localparam int DB_CYC     = cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int BEEP_TICKS = BEEP_SEC * TICK_HZ;
   localparam int TW         = $clog2(TICK_DIV);
   localparam int BW         = $clog2(BEEP_TICKS + 1);

   logic p_start, p_mode, p_clr;
   logic ev_start, ev_mode, ev_clr, any_ev;

   key_debounce #(.DB_CYC(DB_CYC)) u_db_start (.clk(clk), .reset(reset), .key_n(key_start), .press(p_start));
   key_debounce #(.DB_CYC(DB_CYC)) u_db_mode  (.clk(clk), .reset(reset), .key_n(key_mode),  .press(p_mode));
   key_debounce #(.DB_CYC(DB_CYC)) u_db_clear (.clk(clk), .reset(reset), .key_n(key_clear), .press(p_clr));

   // one event per cycle: clear > start > mode
   assign ev_clr   = p_clr;
   assign ev_start = p_start & ~p_clr;
   assign ev_mode  = p_mode & ~p_clr & ~p_start;
   assign any_ev   = ev_clr | ev_start | ev_mode;

   logic [TW-1:0] tick_cnt;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                              tick_cnt <= '0;
      else if (tick_cnt == TW'(TICK_DIV - 1))  tick_cnt <= '0;
      else                                     tick_cnt <= tick_cnt + 1'b1;
   end
   assign tick = (tick_cnt == TW'(TICK_DIV - 1));

   logic       mode, mode_nx;
   sw_state_t  sw_state, sw_nx;
   tmr_state_t tmr_state, tmr_nx;
   logic       sw_clr_q, sw_clr_nx;
   logic [BW-1:0] beep_cnt;
   logic       beep_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode      <= MODE_SW;
         sw_state  <= SW_STOP;
         tmr_state <= T_SET;
         sw_clr_q  <= 1'b0;
      end else begin
         mode      <= mode_nx;
         sw_state  <= sw_nx;
         tmr_state <= tmr_nx;
         sw_clr_q  <= sw_clr_nx;
      end
   end

   // alarm tick count; held at zero outside T_ALARM so it starts fresh on entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  beep_cnt <= '0;
      else if (tmr_state != T_ALARM) beep_cnt <= '0;
      else if (tick)               beep_cnt <= beep_cnt + 1'b1;
   end
   assign beep_done = tick && (beep_cnt == BW'(BEEP_TICKS - 1));

   always_comb begin
      mode_nx   = mode;
      sw_nx     = sw_state;
      tmr_nx    = tmr_state;
      sw_clr_nx = 1'b0;
      if (tmr_state == T_ALARM) begin
         // keys only silence the alarm here
         if (any_ev || beep_done) tmr_nx = T_SET;
      end else begin
         if (ev_mode) mode_nx = ~mode;
         if (mode == MODE_SW) begin
            if (ev_start) sw_nx = (sw_state == SW_RUN) ? SW_STOP : SW_RUN;
            if (ev_clr && sw_state == SW_STOP) sw_clr_nx = 1'b1;
         end
         case (tmr_state)
            T_SET:   if (mode == MODE_TMR && ev_start && !tmr_zero) tmr_nx = T_RUN;
            T_RUN: begin
               if (tmr_zero)                           tmr_nx = T_ALARM;
               else if (mode == MODE_TMR && ev_clr)    tmr_nx = T_SET;
               else if (mode == MODE_TMR && ev_start)  tmr_nx = T_PAUSE;
            end
            T_PAUSE: begin
               if (mode == MODE_TMR && ev_clr)         tmr_nx = T_SET;
               else if (mode == MODE_TMR && ev_start)  tmr_nx = T_RUN;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sw_run    = (sw_state == SW_RUN);
      sw_clear  = sw_clr_q;
      tmr_load  = (tmr_state == T_SET);
      tmr_run   = (tmr_state == T_RUN);
      buzzer_en = (tmr_state == T_ALARM);
      disp_sel  = mode | (tmr_state == T_ALARM);
   end

`ifdef WATCH_CTRL_LAP_EN
   logic freeze;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         freeze <= 1'b0;
      else if (sw_state == SW_RUN && sw_nx == SW_STOP)
         freeze <= 1'b0;
      else if (tmr_state != T_ALARM && mode == MODE_SW && ev_clr && sw_state == SW_RUN)
         freeze <= ~freeze;
   end
   assign disp_freeze = freeze;
`else
   assign disp_freeze = 1'b0;
`endif
endmodule

// File: tb/tb_watch_ctrl.sv
// Self-checking bench for watch_ctrl: vector table plus hand sequences, scoreboard-checked.
module tb_watch_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_start = 1'b1, key_mode = 1'b1, key_clear = 1'b1, tmr_zero = 1'b0;
   logic tick, sw_run, sw_clear, tmr_load, tmr_run, disp_sel, buzzer_en, disp_freeze;

   always #5 clk = ~clk;

   watch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_MS(2), .BEEP_SEC(1)) dut (
      .clk(clk), .reset(rst_n), .key_start(key_start), .key_mode(key_mode),
      .key_clear(key_clear), .tmr_zero(tmr_zero), .tick(tick), .sw_run(sw_run),
      .sw_clear(sw_clear), .tmr_load(tmr_load), .tmr_run(tmr_run), .disp_sel(disp_sel),
      .buzzer_en(buzzer_en), .disp_freeze(disp_freeze)
   );

`ifdef WATCH_CTRL_LAP_EN
   localparam logic LAP = 1'b1;
`else
   localparam logic LAP = 1'b0;
`endif

   logic [7:0] outs;
   assign outs = {tick, sw_run, sw_clear, tmr_load, tmr_run, disp_sel, buzzer_en, disp_freeze};

   typedef struct { string name; logic [2:0] keys; logic tz; int n; logic [7:0] exp; } vec_t;
   typedef struct { string name; logic [7:0] exp; logic [7:0] mask; } sb_t;

   sb_t  sb[$];
   vec_t vecs[16];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [7:0] mk(input logic r, input logic c, input logic ld,
                                     input logic tr, input logic sel, input logic bz, input logic fz);
      return {1'b0, r, c, ld, tr, sel, bz, fz};
   endfunction

   task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %b want %b (tick,sw_run,sw_clear,load,run,sel,buz,frz)", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         cmp(e.name, outs & e.mask, e.exp & e.mask);
      end
   end

   // keys = {start, mode, clear}, 1 = held down; expectation checked at the following negedge
   task automatic step(input logic [2:0] keys, input logic tz, input int n,
                       input string nm, input logic [7:0] exp);
      key_start = ~keys[2];
      key_mode  = ~keys[1];
      key_clear = ~keys[0];
      tmr_zero  = tz;
      repeat (n) @(posedge clk);
      #1;
      sb.push_back('{nm, exp, 8'h7F});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] I, R, M, TR, AL;
      int d;
      I  = mk(0,0,1,0,0,0,0);
      R  = mk(1,0,1,0,0,0,0);
      M  = mk(0,0,1,0,1,0,0);
      TR = mk(0,0,0,1,1,0,0);
      AL = mk(0,0,0,0,1,1,0);

      vecs[0]  = '{"glitch",      3'b100, 1'b0, 1, I};
      vecs[1]  = '{"glitch_rel",  3'b000, 1'b0, 8, I};
      vecs[2]  = '{"start_4",     3'b100, 1'b0, 4, I};
      vecs[3]  = '{"start_5",     3'b100, 1'b0, 1, R};
      vecs[4]  = '{"start_hold",  3'b100, 1'b0, 5, R};
      vecs[5]  = '{"start_rel",   3'b000, 1'b0, 8, R};
      vecs[6]  = '{"sw_stop",     3'b100, 1'b0, 6, I};
      vecs[7]  = '{"stop_rel",    3'b000, 1'b0, 8, I};
      vecs[8]  = '{"clr_pulse",   3'b001, 1'b0, 5, mk(0,1,1,0,0,0,0)};
      vecs[9]  = '{"clr_end",     3'b001, 1'b0, 1, I};
      vecs[10] = '{"clr_rel",     3'b000, 1'b0, 8, I};
      vecs[11] = '{"mode_tmr",    3'b010, 1'b0, 5, M};
      vecs[12] = '{"mode_rel",    3'b000, 1'b0, 8, M};
      vecs[13] = '{"tmr_start",   3'b100, 1'b0, 5, TR};
      vecs[14] = '{"tmr_rel",     3'b000, 1'b0, 8, TR};
      vecs[15] = '{"alarm_entry", 3'b000, 1'b1, 1, AL};

      // reset state while reset is held
      repeat (3) @(posedge clk);
      #1;
      sb.push_back('{"reset_state", I, 8'hFF});
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // free-running tick: high after the 9th, 19th, ... edge following release
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk);
         #1;
         sb.push_back('{$sformatf("tick_c%0d", k), {(k % 10 == 9), I[6:0]}, 8'hFF});
      end

      for (int i = 0; i < 16; i++)
         step(vecs[i].keys, vecs[i].tz, vecs[i].n, vecs[i].name, vecs[i].exp);

      // alarm auto-silence after 100 ticks: 991..1000 cycles depending on tick phase
      d = 0;
      @(negedge clk);
      while (buzzer_en && d < 1100) begin
         @(posedge clk);
         d++;
         @(negedge clk);
      end
      n_tests++;
      if (d < 991 || d > 1000) begin
         n_fail++;
         $display("FAIL alarm_len got %0d cycles want 991..1000", d);
      end
      step(3'b000, 1'b1, 1, "alarm_done", M);

      // alarm silenced by a mode key; mode must stay on the timer
      step(3'b000, 1'b0, 8, "rearm_set",   M);
      step(3'b100, 1'b0, 5, "rearm_run",   TR);
      step(3'b000, 1'b0, 8, "rearm_rel",   TR);
      step(3'b000, 1'b1, 1, "rearm_alarm", AL);
      step(3'b010, 1'b1, 4, "alarm_key_4", AL);
      step(3'b010, 1'b1, 1, "alarm_key_5", M);
      step(3'b000, 1'b1, 8, "alarm_key_rel", M);

      // start and clear together in T_RUN: clear wins
      step(3'b000, 1'b0, 2, "pre_run2",   M);
      step(3'b100, 1'b0, 5, "run2",       TR);
      step(3'b000, 1'b0, 8, "run2_rel",   TR);
      step(3'b101, 1'b0, 5, "start_clr",  M);
      step(3'b000, 1'b0, 8, "start_clr_rel", M);
      // start with timer already at zero is ignored
      step(3'b100, 1'b1, 5, "start_zero", M);
      step(3'b000, 1'b1, 8, "start_zero_rel", M);

      // lap hold in stopwatch mode
      step(3'b010, 1'b0, 5, "to_sw",     I);
      step(3'b000, 1'b0, 8, "to_sw_rel", I);
      step(3'b100, 1'b0, 5, "lap_run",   R);
      step(3'b000, 1'b0, 8, "lap_run_rel", R);
      step(3'b001, 1'b0, 5, "lap_clr",   mk(1,0,1,0,0,0,LAP));
      step(3'b000, 1'b0, 8, "lap_hold",  mk(1,0,1,0,0,0,LAP));
      step(3'b100, 1'b0, 5, "lap_stop",  I);
      step(3'b000, 1'b0, 8, "lap_stop_rel", I);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
